mpf_vtp_pt_host_bridge: RTL
===========================

// Module: mpf_vtp_pt_host_bridge
// PURPOSE
//   Host-side responder for the VTP page-table host interface.
//   - Accepts page-table read/write requests from the VTP walker (HW walker or SW service).
//   - Issues them on a tagged valid/ready host memory channel.
//   - Returns read data to the walker in request order, tracking out-of-order host responses in a reorder buffer.
//   - Enforces write-before-read ordering.
// PARAMETERS
//   N_OUTSTANDING  4    max reads in flight (power of 2, >=2); tag width TW=$clog2(N_OUTSTANDING)
//   ADDR_WIDTH     42   line address width
//   DATA_WIDTH     512  read line width
//   WR_DATA_WIDTH  64   page-table write width
// PORTS
//   clk              in   1     clock
//   reset            in   1     asynchronous, active-high reset
//   pt_rd_en         in   1     walker read request; legal only when pt_rd_not_full
//   pt_rd_addr       in   AW    read line address
//   pt_rd_not_full   out  1     bridge can accept a read this cycle
//   pt_rd_data_valid out  1     read data returned (in request order)
//   pt_rd_data       out  DW    read data
//   pt_wr_en         in   1     walker write request; legal only when pt_wr_not_full
//   pt_wr_addr       in   AW    write address
//   pt_wr_data       in   WDW   write data
//   pt_wr_not_full   out  1     bridge can accept a write this cycle
//   pt_wr_pending    out  1     any write accepted but not yet acked
//   host_rd_valid    out  1     host read request valid
//   host_rd_ready    in   1     host accepts read request
//   host_rd_addr     out  AW    host read address
//   host_rd_tag      out  TW    host read tag
//   host_rsp_valid   in   1     host read response valid (any order)
//   host_rsp_tag     in   TW    tag of response
//   host_rsp_data    in   DW    response data
//   host_wr_valid    out  1     host write request valid
//   host_wr_ready    in   1     host accepts write
//   host_wr_addr     out  AW    host write address
//   host_wr_data     out  WDW   host write data
//   host_wr_ack      in   1     one pulse per completed write
//   err_bad_tag      out  1     sticky: response for an unallocated tag
// BEHAVIOUR
//   Reset:
//   - All outputs are 0 except pt_rd_not_full=1 and pt_wr_not_full=1.
//   - ROB head/tail, counters and slot-valid bits clear; any in-flight state is discarded.
//   Read path:
//   - rd_inflight counts accept-to-delivery, range 0..N.
//   - pt_rd_not_full = !rd_req_q_valid && rd_inflight<N.
//   - On pt_rd_en, register the address into rd_req_q and allocate tag=alloc_ptr; alloc_ptr++ (mod N wrap).
//   - host_rd_valid = rd_req_q_valid && !wr_q_valid && wr_outstanding==0 (write fence). Earliest issue is cycle t+1 after pt_rd_en at t.
//   - Handshake: host_rd_valid&&host_rd_ready clears rd_req_q. Address and tag stay stable while valid && !ready.
//   - On host_rsp_valid, if slot[tag] is allocated and not yet filled, store the data and mark it filled. Otherwise set err_bad_tag; data is dropped.
//   - Delivery: when slot[deliver_ptr] is filled, pt_rd_data_valid pulses for 1 cycle (registered). Then free the slot, deliver_ptr++, rd_inflight--.
//   - Latency: a response to the oldest tag at cycle t produces pt_rd_data_valid at t+1. Responses to younger tags wait.
//   - Same-cycle accept and deliver leaves rd_inflight unchanged.
//   - A response to tag X and delivery of a different slot in the same cycle are both honoured.
//   Write path:
//   - pt_wr_not_full = !wr_q_valid && wr_outstanding<N.
//   - On pt_wr_en, register into wr_q; host_wr_valid = wr_q_valid.
//   - Handshake with host_wr_ready clears wr_q and increments wr_outstanding; host_wr_ack decrements it.
//   - Issue and ack in the same cycle leave wr_outstanding unchanged. An ack at wr_outstanding==0 sets err_bad_tag.
//   - pt_wr_pending = wr_q_valid || wr_outstanding!=0.
//   Ordering:
//   - Reads wait behind all earlier-accepted writes until acked; writes are never blocked by reads.
//   - Simultaneous pt_rd_en and pt_wr_en in one cycle: the write is ordered first.
//   Errors: err_bad_tag stays set until reset.
// TESTING
//   1. Single read addr 0x100; host ready, responds tag0 data 0xA5.. after 5 cycles -> host_rd_valid at t+1 with tag 0; pt_rd_data_valid 1 cycle after response, data 0xA5..
//   2. 4 reads (N=4), host returns tags 3,1,0,2 -> pt_rd_not_full=0 after 4th accept; data delivered in order 0,1,2,3; deliveries for tags 0,1 occur back-to-back after tag-0 response.
//   3. Write addr 0x20 then read 0x20 in the next cycle; host acks after 8 cycles -> host_rd_valid stays 0 until the cycle after host_wr_ack; pt_wr_pending high throughout.
//   4. host_rd_ready held 0 for 10 cycles -> host_rd_addr/tag stable, pt_rd_not_full=0; release -> single request issued.
//   5. host_rsp_valid with unallocated tag 2 when idle -> err_bad_tag=1 and sticky; no pt_rd_data_valid.
//   6. Assert reset with 3 reads in flight -> all outputs at reset values same cycle; next read after reset gets tag 0.

Source files
------------

// File: rtl/mpf_vtp_pt_host_bridge.sv
// VTP page-table host bridge: walker reads and writes go to a tagged host channel.
// Reads return in request order through a small reorder buffer and wait behind unacked writes.
module mpf_vtp_pt_host_bridge #(
    parameter int N_OUTSTANDING = 4,
    parameter int ADDR_WIDTH    = 42,
    parameter int DATA_WIDTH    = 512,
    parameter int WR_DATA_WIDTH = 64,
    localparam int TW = $clog2(N_OUTSTANDING),
    localparam int CW = TW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pt_rd_en,
    input  logic [ADDR_WIDTH-1:0]    pt_rd_addr,
    output logic                     pt_rd_not_full,
    output logic                     pt_rd_data_valid,
    output logic [DATA_WIDTH-1:0]    pt_rd_data,
    input  logic                     pt_wr_en,
    input  logic [ADDR_WIDTH-1:0]    pt_wr_addr,
    input  logic [WR_DATA_WIDTH-1:0] pt_wr_data,
    output logic                     pt_wr_not_full,
    output logic                     pt_wr_pending,
    output logic                     host_rd_valid,
    input  logic                     host_rd_ready,
    output logic [ADDR_WIDTH-1:0]    host_rd_addr,
    output logic [TW-1:0]            host_rd_tag,
    input  logic                     host_rsp_valid,
    input  logic [TW-1:0]            host_rsp_tag,
    input  logic [DATA_WIDTH-1:0]    host_rsp_data,
    output logic                     host_wr_valid,
    input  logic                     host_wr_ready,
    output logic [ADDR_WIDTH-1:0]    host_wr_addr,
    output logic [WR_DATA_WIDTH-1:0] host_wr_data,
    input  logic                     host_wr_ack,
    output logic                     err_bad_tag
);

    logic                     rd_v_q;
    logic [ADDR_WIDTH-1:0]    rd_addr_q;
    logic [TW-1:0]            rd_tag_q;
    logic [TW-1:0]            alloc_ptr_q;
    logic [TW-1:0]            dlv_ptr_q;
    logic [CW-1:0]            rd_inflight_q;
    logic [CW-1:0]            rd_inflight_d;
    logic [N_OUTSTANDING-1:0] slot_alloc_q;
    logic [N_OUTSTANDING-1:0] slot_fill_q;
    logic [DATA_WIDTH-1:0]    slot_data_q [N_OUTSTANDING];
    logic                     dv_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     wr_v_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [WR_DATA_WIDTH-1:0] wr_data_q;
    logic [CW-1:0]            wr_out_q;
    logic [CW-1:0]            wr_out_d;
    logic                     err_q;

    logic                  rd_accept;
    logic                  rd_issue;
    logic                  wr_accept;
    logic                  wr_issue;
    logic                  ack_ok;
    logic                  rsp_ok;
    logic                  bypass;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] deliver_data;

    assign pt_rd_not_full = !rd_v_q &&
                            (rd_inflight_q < CW'(N_OUTSTANDING));
    assign pt_wr_not_full = !wr_v_q &&
                            (wr_out_q < CW'(N_OUTSTANDING));
    assign host_rd_valid  = rd_v_q && !wr_v_q && (wr_out_q == '0);
    assign host_rd_addr   = rd_addr_q;
    assign host_rd_tag    = rd_tag_q;
    assign host_wr_valid  = wr_v_q;
    assign host_wr_addr   = wr_addr_q;
    assign host_wr_data   = wr_data_q;
    assign pt_wr_pending  = wr_v_q || (wr_out_q != '0);
    assign pt_rd_data_valid = dv_q;
    assign pt_rd_data     = rdata_q;
    assign err_bad_tag    = err_q;

    assign rd_accept = pt_rd_en && pt_rd_not_full;
    assign rd_issue  = host_rd_valid && host_rd_ready;
    assign wr_accept = pt_wr_en && pt_wr_not_full;
    assign wr_issue  = wr_v_q && host_wr_ready;
    assign ack_ok    = host_wr_ack && (wr_out_q != '0);

    // A response to the head slot is forwarded straight to the output register.
    assign rsp_ok  = host_rsp_valid && slot_alloc_q[host_rsp_tag] &&
                     !slot_fill_q[host_rsp_tag];
    assign bypass  = rsp_ok && (host_rsp_tag == dlv_ptr_q);
    assign deliver = slot_fill_q[dlv_ptr_q] || bypass;
    assign deliver_data = slot_fill_q[dlv_ptr_q] ? slot_data_q[dlv_ptr_q]
                                                 : host_rsp_data;

    assign rd_inflight_d = rd_inflight_q + CW'(rd_accept) - CW'(deliver);
    assign wr_out_d      = wr_out_q + CW'(wr_issue) - CW'(ack_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v_q        <= 1'b0;
            rd_addr_q     <= '0;
            rd_tag_q      <= '0;
            alloc_ptr_q   <= '0;
            dlv_ptr_q     <= '0;
            rd_inflight_q <= '0;
            slot_alloc_q  <= '0;
            slot_fill_q   <= '0;
            dv_q          <= 1'b0;
            rdata_q       <= '0;
            wr_v_q        <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_out_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            if (rd_issue) begin
                rd_v_q <= 1'b0;
            end
            if (rd_accept) begin
                rd_v_q      <= 1'b1;
                rd_addr_q   <= pt_rd_addr;
                rd_tag_q    <= alloc_ptr_q;
                alloc_ptr_q <= alloc_ptr_q + TW'(1);
            end
            for (int i = 0; i < N_OUTSTANDING; i++) begin
                if (rd_accept && alloc_ptr_q == TW'(i)) begin
                    slot_alloc_q[i] <= 1'b1;
                    slot_fill_q[i]  <= 1'b0;
                end
                if (rsp_ok && !bypass && host_rsp_tag == TW'(i)) begin
                    slot_fill_q[i] <= 1'b1;
                end
                if (deliver && dlv_ptr_q == TW'(i)) begin
                    slot_alloc_q[i] <= 1'b0;
                    slot_fill_q[i]  <= 1'b0;
                end
            end
            dv_q <= deliver;
            if (deliver) begin
                rdata_q   <= deliver_data;
                dlv_ptr_q <= dlv_ptr_q + TW'(1);
            end
            rd_inflight_q <= rd_inflight_d;
            if (wr_issue) begin
                wr_v_q <= 1'b0;
            end
            if (wr_accept) begin
                wr_v_q    <= 1'b1;
                wr_addr_q <= pt_wr_addr;
                wr_data_q <= pt_wr_data;
            end
            wr_out_q <= wr_out_d;
            if ((host_rsp_valid && !rsp_ok) ||
                (host_wr_ack && wr_out_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_OUTSTANDING; i++) begin
            if (rsp_ok && !bypass && host_rsp_tag == TW'(i)) begin
                slot_data_q[i] <= host_rsp_data;
            end
        end
    end

endmodule
